ssd_scan_ctrl: RTL and testbench

//  Downstream of the per-digit SSD decoders. Time-multiplexes four 15-bit active-low segment

---
 rtl/ssd_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : Four-digit segment-bus scanner. It uses active-low segments and
//               enables, inserts a blanking gap between digits, and applies
//               pattern updates only on frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        orig_clk,
    input  logic        rst,
    input  logic [14:0] ssd_in0,
    input  logic [14:0] ssd_in1,
    input  logic [14:0] ssd_in2,
    input  logic [14:0] ssd_in3,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic        blank_all,
    output logic [14:0] D_ssd,
    output logic [3:0]  d_en,
    output logic        frame_tick
);

    localparam int              C_CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(SCAN_DIV - 1);
    localparam logic [C_CW-1:0] C_BLANK   = C_CW'(BLANK_CYC);
    localparam logic [C_CW-1:0] C_ONE     = C_CW'(1);
    localparam logic [14:0]     C_DARK    = 15'h7FFF;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t          r_state;
    logic [C_CW-1:0] r_cnt;
    logic [1:0]      r_dig;
    logic [14:0]     r_active [4];
    logic [14:0]     r_shadow [4];
    logic            r_pending;
    logic            r_ready;
    logic [14:0]     r_d_ssd;
    logic [3:0]      r_d_en;
    logic            r_frame_tick;

    logic            w_slot_end;
    logic            w_frame_end;
    logic [C_CW-1:0] w_cnt_nxt;
    logic [1:0]      w_dig_nxt;
    logic            w_capture;
    logic            w_commit;
    state_t          w_state_nxt;
    logic [14:0]     w_pattern;
    logic [14:0]     w_d_ssd_nxt;
    logic [3:0]      w_d_en_nxt;

    assign w_slot_end  = (r_cnt == C_CNT_MAX);
    assign w_frame_end = w_slot_end && (r_dig == 2'd3);
    assign w_cnt_nxt   = w_slot_end ? '0 : (r_cnt + C_ONE);
    assign w_dig_nxt   = w_slot_end ? (r_dig + 2'd1) : r_dig;
    assign w_capture   = upd_valid && r_ready;
    assign w_commit    = w_frame_end && r_pending;

    // Outputs are registered from next-cycle counter values so that the bus
    // lines up with cnt/dig in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BLANK: if (w_cnt_nxt >= C_BLANK) w_state_nxt = ST_DRIVE;
            ST_DRIVE: if (w_cnt_nxt <  C_BLANK) w_state_nxt = ST_BLANK;
            default:  w_state_nxt = ST_BLANK;
        endcase
    end

    // A committing edge must already show the new frame's data.
    assign w_pattern = w_commit ? r_shadow[w_dig_nxt] : r_active[w_dig_nxt];

    always_comb begin
        w_d_ssd_nxt = C_DARK;
        w_d_en_nxt  = 4'b1111;
        if (!blank_all && (w_state_nxt == ST_DRIVE)) begin
            w_d_ssd_nxt = w_pattern;
            w_d_en_nxt  = ~(4'b0001 << w_dig_nxt);
        end
    end

    always_ff @(posedge orig_clk) begin
        if (rst) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_dig        <= 2'd0;
            r_pending    <= 1'b0;
            r_ready      <= 1'b1;
            r_d_ssd      <= C_DARK;
            r_d_en       <= 4'b1111;
            r_frame_tick <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_active[i] <= C_DARK;
                r_shadow[i] <= C_DARK;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dig        <= w_dig_nxt;
            r_d_ssd      <= w_d_ssd_nxt;
            r_d_en       <= w_d_en_nxt;
            r_frame_tick <= w_frame_end;
            // Ready implies nothing is pending, so capture and commit never coincide.
            if (w_capture) begin
                r_shadow[0] <= ssd_in0;
                r_shadow[1] <= ssd_in1;
                r_shadow[2] <= ssd_in2;
                r_shadow[3] <= ssd_in3;
                r_pending   <= 1'b1;
                r_ready     <= 1'b0;
            end else if (w_commit) begin
                for (int i = 0; i < 4; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_pending <= 1'b0;
                r_ready   <= 1'b1;
            end
        end
    end

    assign upd_ready  = r_ready;
    assign D_ssd      = r_d_ssd;
    assign d_en       = r_d_en;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_ctrl
// Description : Scoreboard bench for ssd_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_ctrl;

    localparam int          SCAN  = 8;
    localparam int          BLANK = 2;
    localparam int          FRAME = 4 * SCAN;
    localparam logic [14:0] DARK  = 15'h7FFF;

    typedef struct packed {
        logic [14:0] d;
        logic [3:0]  en;
        logic        rdy;
        logic        tick;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] in0 = DARK, in1 = DARK, in2 = DARK, in3 = DARK;
    logic        upd_valid = 1'b0;
    logic        blank_all = 1'b0;
    logic        upd_ready;
    logic [14:0] D_ssd;
    logic [3:0]  d_en;
    logic        frame_tick;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    obs_t exp_q[$];

    ssd_scan_ctrl #(.SCAN_DIV(SCAN), .BLANK_CYC(BLANK)) dut (
        .orig_clk  (clk),
        .rst       (rst),
        .ssd_in0   (in0),
        .ssd_in1   (in1),
        .ssd_in2   (in2),
        .ssd_in3   (in3),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .blank_all (blank_all),
        .D_ssd     (D_ssd),
        .d_en      (d_en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: cycle count since reset decides slot and position.
    int          m_t;
    logic [14:0] m_active [4];
    logic [14:0] m_shadow [4];
    bit          m_pending, m_ready, m_init = 1'b0;

    always @(posedge clk) begin : p_model
        bit   commit, cap;
        int   pos, dig;
        obs_t e;
        if (rst) begin
            m_init = 1'b1; m_t = 0; m_pending = 1'b0; m_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin m_active[i] = DARK; m_shadow[i] = DARK; end
            exp_q.push_back('{DARK, 4'b1111, 1'b1, 1'b0});
        end else if (m_init) begin
            commit = (((m_t + 1) % FRAME) == 0) && m_pending;
            cap    = upd_valid && m_ready;
            if (commit) begin
                for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
                m_pending = 1'b0; m_ready = 1'b1;
            end
            if (cap) begin
                m_shadow[0] = in0; m_shadow[1] = in1; m_shadow[2] = in2; m_shadow[3] = in3;
                m_pending = 1'b1; m_ready = 1'b0;
            end
            m_t++;
            pos = m_t % SCAN;
            dig = (m_t / SCAN) % 4;
            if (blank_all || pos < BLANK) begin
                e.d = DARK; e.en = 4'b1111;
            end else begin
                e.d = m_active[dig]; e.en = ~(4'b0001 << dig);
            end
            e.rdy  = m_ready;
            e.tick = ((m_t % FRAME) == 0);
            exp_q.push_back(e);
        end
    end

    task automatic apply_reset();
        rst = 1'b1; upd_valid = 1'b0; blank_all = 1'b0;
        in0 = DARK; in1 = DARK; in2 = DARK; in3 = DARK;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        obs_t got, e;
        apply_reset();
        total++;
        if (exp_q.size() == 0) begin
            bad++; $display("FAIL reset_sb: no expected entry");
        end else begin
            e = exp_q.pop_front(); got = {D_ssd, d_en, upd_ready, frame_tick};
            if (got !== e) begin bad++; $display("FAIL reset_sb got=%h exp=%h", got, e); end
        end
        total++;
        if ({D_ssd, d_en, upd_ready, frame_tick} !== {DARK, 4'b1111, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals got D=%h en=%b rdy=%b tick=%b exp D=7fff en=1111 rdy=1 tick=0",
                     D_ssd, d_en, upd_ready, frame_tick);
        end
    endtask

    task automatic test_scan();
        obs_t got, e;
        apply_reset();
        while (cyc <= 40) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL scan_sb cyc=%0d no expected entry", cyc);
            end else begin
                e = exp_q.pop_front(); got = {D_ssd, d_en, upd_ready, frame_tick};
                if (got !== e) begin bad++; $display("FAIL scan_sb cyc=%0d got=%h exp=%h", cyc, got, e); end
            end
            if (cyc == 1)  begin total++; if (d_en !== 4'b1111) begin bad++; $display("FAIL scan_blank1 got=%b exp=1111", d_en); end end
            if (cyc == 2)  begin total++; if (d_en !== 4'b1110) begin bad++; $display("FAIL scan_dig0 got=%b exp=1110", d_en); end end
            if (cyc == 9)  begin total++; if (d_en !== 4'b1111) begin bad++; $display("FAIL scan_gap1 got=%b exp=1111", d_en); end end
            if (cyc == 10) begin total++; if (d_en !== 4'b1101) begin bad++; $display("FAIL scan_dig1 got=%b exp=1101", d_en); end end
            if (cyc == 31) begin total++; if ({d_en, frame_tick} !== 5'b01110) begin bad++; $display("FAIL scan_dig3 got en=%b tick=%b exp en=0111 tick=0", d_en, frame_tick); end end
            if (cyc == 32) begin total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL scan_tick got=%b exp=1", frame_tick); end end
            if (cyc == 33) begin total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL scan_tick_len got=%b exp=0", frame_tick); end end
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_update();
        obs_t got, e;
        apply_reset();
        while (cyc <= 40) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL upd_sb cyc=%0d no expected entry", cyc);
            end else begin
                e = exp_q.pop_front(); got = {D_ssd, d_en, upd_ready, frame_tick};
                if (got !== e) begin bad++; $display("FAIL upd_sb cyc=%0d got=%h exp=%h", cyc, got, e); end
            end
            if (cyc == 6)  begin total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL upd_ready_low got=%b exp=0", upd_ready); end end
            if (cyc == 31) begin total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL upd_ignore_hold got=%b exp=0", upd_ready); end end
            if (cyc == 32) begin total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL upd_ready_back got=%b exp=1", upd_ready); end end
            if (cyc == 34) begin total++; if ({D_ssd, d_en} !== {15'h01FF, 4'b1110}) begin bad++; $display("FAIL upd_show got D=%h en=%b exp D=01ff en=1110", D_ssd, d_en); end end
            case (cyc)
                5:  begin upd_valid = 1'b1; in0 = 15'h01FF; end
                6:  upd_valid = 1'b0;
                10: begin upd_valid = 1'b1; in0 = 15'h0AAA; in1 = 15'h0555; end
                12: upd_valid = 1'b0;
                default: ;
            endcase
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_boundary();
        obs_t got, e;
        apply_reset();
        while (cyc <= 100) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL bnd_sb cyc=%0d no expected entry", cyc);
            end else begin
                e = exp_q.pop_front(); got = {D_ssd, d_en, upd_ready, frame_tick};
                if (got !== e) begin bad++; $display("FAIL bnd_sb cyc=%0d got=%h exp=%h", cyc, got, e); end
            end
            if (cyc == 64) begin total++; if ({upd_ready, frame_tick} !== 2'b01) begin bad++; $display("FAIL bnd_capture got rdy=%b tick=%b exp rdy=0 tick=1", upd_ready, frame_tick); end end
            if (cyc == 66) begin total++; if (D_ssd !== 15'h0123) begin bad++; $display("FAIL bnd_old got=%h exp=0123", D_ssd); end end
            if (cyc == 96) begin total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL bnd_ready got=%b exp=1", upd_ready); end end
            if (cyc == 98) begin total++; if (D_ssd !== 15'h0456) begin bad++; $display("FAIL bnd_new got=%h exp=0456", D_ssd); end end
            case (cyc)
                3:  begin upd_valid = 1'b1; in0 = 15'h0123; end
                4:  upd_valid = 1'b0;
                63: begin upd_valid = 1'b1; in0 = 15'h0456; end
                64: upd_valid = 1'b0;
                default: ;
            endcase
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_blank_all();
        obs_t got, e;
        apply_reset();
        while (cyc <= 56) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL blk_sb cyc=%0d no expected entry", cyc);
            end else begin
                e = exp_q.pop_front(); got = {D_ssd, d_en, upd_ready, frame_tick};
                if (got !== e) begin bad++; $display("FAIL blk_sb cyc=%0d got=%h exp=%h", cyc, got, e); end
            end
            if (cyc == 20) begin total++; if ({D_ssd, d_en} !== {DARK, 4'b1111}) begin bad++; $display("FAIL blk_dark1 got D=%h en=%b exp D=7fff en=1111", D_ssd, d_en); end end
            if (cyc == 32) begin total++; if ({upd_ready, frame_tick} !== 2'b11) begin bad++; $display("FAIL blk_commit got rdy=%b tick=%b exp rdy=1 tick=1", upd_ready, frame_tick); end end
            if (cyc == 50) begin total++; if ({D_ssd, d_en} !== {DARK, 4'b1111}) begin bad++; $display("FAIL blk_dark2 got D=%h en=%b exp D=7fff en=1111", D_ssd, d_en); end end
            if (cyc == 52) begin total++; if ({D_ssd, d_en} !== {15'h1555, 4'b1011}) begin bad++; $display("FAIL blk_resume got D=%h en=%b exp D=1555 en=1011", D_ssd, d_en); end end
            case (cyc)
                3:  begin upd_valid = 1'b1; in2 = 15'h1555; end
                4:  upd_valid = 1'b0;
                15: blank_all = 1'b1;
                23: blank_all = 1'b0;
                47: blank_all = 1'b1;
                51: blank_all = 1'b0;
                default: ;
            endcase
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_mid_reset();
        obs_t got, e;
        apply_reset();
        while (cyc <= 13) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL mrst_pre_sb cyc=%0d no expected entry", cyc);
            end else begin
                e = exp_q.pop_front(); got = {D_ssd, d_en, upd_ready, frame_tick};
                if (got !== e) begin bad++; $display("FAIL mrst_pre_sb cyc=%0d got=%h exp=%h", cyc, got, e); end
            end
            if (cyc == 10) begin total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL mrst_pending got=%b exp=0", upd_ready); end end
            case (cyc)
                3: begin upd_valid = 1'b1; in0 = 15'h0F0F; end
                4: upd_valid = 1'b0;
                default: ;
            endcase
            if (cyc < 13) begin @(negedge clk); cyc++; end
            else break;
        end
        apply_reset();
        while (cyc <= 40) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL mrst_sb cyc=%0d no expected entry", cyc);
            end else begin
                e = exp_q.pop_front(); got = {D_ssd, d_en, upd_ready, frame_tick};
                if (got !== e) begin bad++; $display("FAIL mrst_sb cyc=%0d got=%h exp=%h", cyc, got, e); end
            end
            if (cyc == 0)  begin total++; if ({d_en, upd_ready} !== 5'b11111) begin bad++; $display("FAIL mrst_state got en=%b rdy=%b exp en=1111 rdy=1", d_en, upd_ready); end end
            if (cyc == 2)  begin total++; if ({D_ssd, d_en} !== {DARK, 4'b1110}) begin bad++; $display("FAIL mrst_restart got D=%h en=%b exp D=7fff en=1110", D_ssd, d_en); end end
            if (cyc == 34) begin total++; if ({D_ssd, d_en} !== {DARK, 4'b1110}) begin bad++; $display("FAIL mrst_discard got D=%h en=%b exp D=7fff en=1110", D_ssd, d_en); end end
            @(negedge clk); cyc++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan();
        test_update();
        test_boundary();
        test_blank_all();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
